// File: rtl/addc_pkg.sv
// Shared types, defaults and the sign-magnitude adder used by the multi-channel ADDC stage.
package addc_pkg;
  localparam int NCH_DEF         = 4;
  localparam int DQW_DEF         = 16;
  localparam int SEZW_DEF        = 15;
  localparam bit LEGACY_WRAP_DEF = 1'b0;
  localparam int MAXW            = 64;

  typedef struct packed {
    logic pk1;
    logic sig1;
    logic pk2;
    logic sig2;
  } hist_t;

  // Wide enough that the caller just truncates; negative zero falls out as 0.
  function automatic logic signed [MAXW-1:0] addc_sum(input logic dq_sgn,
                                                      input logic [MAXW-1:0] dq_mag,
                                                      input logic signed [MAXW-1:0] sez);
    logic signed [MAXW-1:0] dqi;
    dqi = dq_sgn ? -$signed(dq_mag) : $signed(dq_mag);
    return dqi + sez;
  endfunction
endpackage

// File: rtl/addc_mc_if.sv
// Sample/result handshake bundle for addc_mc; slave is the block's view.
interface addc_mc_if
  import addc_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int DQW         = DQW_DEF,
  parameter int SEZW        = SEZW_DEF,
  parameter bit LEGACY_WRAP = LEGACY_WRAP_DEF
) ();
  localparam int CHW = $clog2(NCH);
  localparam int SW  = LEGACY_WRAP ? DQW : DQW + 1;

  logic            in_valid, in_ready;
  logic [CHW-1:0]  in_ch;
  logic [DQW-1:0]  DQ;
  logic [SEZW-1:0] SEZ;
  logic            clr_valid;
  logic [CHW-1:0]  clr_ch;
  logic            out_valid, out_ready;
  logic [CHW-1:0]  out_ch;
  logic [SW-1:0]   DQSEZ;
  logic            PK0, SIGPK, PK1, PK2, SIG1, SIG2;

  modport slave (
    input  in_valid, in_ch, DQ, SEZ, clr_valid, clr_ch, out_ready,
    output in_ready, out_valid, out_ch, DQSEZ, PK0, SIGPK, PK1, PK2, SIG1, SIG2
  );
  modport master (
    output in_valid, in_ch, DQ, SEZ, clr_valid, clr_ch, out_ready,
    input  in_ready, out_valid, out_ch, DQSEZ, PK0, SIGPK, PK1, PK2, SIG1, SIG2
  );
endinterface

// File: rtl/addc_hist.sv
// Per-channel PK/SIG history; a clear on the channel being written takes priority.
module addc_hist
  import addc_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CHW-1:0] rd_ch,
  output hist_t          rd_data,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic           wr_pk,
  input  logic           wr_sig,
  input  logic           clr_en,
  input  logic [CHW-1:0] clr_ch
);
  hist_t ent_q [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ent
    hist_t ent;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             ent <= '0;
      else if (clr_en && clr_ch == CHW'(i))   ent <= '0;
      else if (wr_en && wr_ch == CHW'(i))
        ent <= '{pk1: wr_pk, sig1: wr_sig, pk2: ent.pk1, sig2: ent.sig1};
    end
    assign ent_q[i] = ent;
  end

  assign rd_data = ent_q[rd_ch];
endmodule

// File: rtl/addc_mc.sv
// Two-stage multi-channel ADDC: DQ+SEZ sum in S1, history lookup/update and outputs in S2.
module addc_mc
  import addc_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int DQW         = DQW_DEF,
  parameter int SEZW        = SEZW_DEF,
  parameter bit LEGACY_WRAP = LEGACY_WRAP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
  input  logic scan_enable, test_mode,
  output logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4,
  addc_mc_if.slave bus
);
  localparam int CHW    = $clog2(NCH);
  localparam int SW     = LEGACY_WRAP ? DQW : DQW + 1;
  localparam int STAGES = 2;

  logic [1:0]      rst_sync;
  logic            rst_n;
  logic            en;
  logic [STAGES:1] vld_pipe;
  logic [CHW-1:0]  s1_ch;
  logic [SW-1:0]   s1_sum, sum_c;
  hist_t           hrd;
  logic            unused_dft;

  assign scan_out0  = 1'b0;
  assign scan_out1  = 1'b0;
  assign scan_out2  = 1'b0;
  assign scan_out3  = 1'b0;
  assign scan_out4  = 1'b0;
  assign unused_dft = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};

  // Async assert, release aligned to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign en            = !vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[STAGES];
  assign sum_c = SW'(addc_sum(bus.DQ[DQW-1], MAXW'(bus.DQ[DQW-2:0]), MAXW'($signed(bus.SEZ))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_ch    <= '0;
      s1_sum   <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
      s1_ch    <= bus.in_ch;
      s1_sum   <= sum_c;
    end
  end

  // History is read and written here only, so same-channel back-to-back needs no bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_ch <= '0;
      bus.DQSEZ  <= '0;
      bus.PK0    <= 1'b0;
      bus.SIGPK  <= 1'b0;
      bus.PK1    <= 1'b0;
      bus.SIG1   <= 1'b0;
      bus.PK2    <= 1'b0;
      bus.SIG2   <= 1'b0;
    end else if (en && vld_pipe[1]) begin
      bus.out_ch <= s1_ch;
      bus.DQSEZ  <= s1_sum;
      bus.PK0    <= s1_sum[SW-1];
      bus.SIGPK  <= (s1_sum == '0);
      bus.PK1    <= hrd.pk1;
      bus.SIG1   <= hrd.sig1;
      bus.PK2    <= hrd.pk2;
      bus.SIG2   <= hrd.sig2;
    end
  end

  addc_hist #(.NCH(NCH), .CHW(CHW)) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_ch   (s1_ch),
    .rd_data (hrd),
    .wr_en   (en & vld_pipe[1]),
    .wr_ch   (s1_ch),
    .wr_pk   (s1_sum[SW-1]),
    .wr_sig  (s1_sum == '0),
    .clr_en  (bus.clr_valid),
    .clr_ch  (bus.clr_ch)
  );
endmodule

// File: doc/addc_mc.md
# addc_mc

Multi-channel, pipelined successor to the single-channel ADDC stage of the ADPCM decoder/encoder datapath. Adds the sign-magnitude quantized difference DQ to the two's-complement partial signal estimate SEZ for up to NCH time-multiplexed channels. Produces the sum sign PK0 and the zero flag SIGPK, plus per-channel history PK1/PK2 and SIG1/SIG2 for the pole-predictor update (UPA1/UPA2). Sits between the inverse quantizer and the predictor-coefficient update blocks, with valid/ready flow control.

## Interface
- NCH, 4, number of channels (≥2)
- DQW, 16, DQ width; MSB is sign, DQW-1 magnitude bits
- SEZW, 15, SEZ width, two's complement; SEZW ≤ DQW required
- LEGACY_WRAP, 0, 1 = sum truncated to DQW bits (single-channel compatible); 0 = full precision
- CHW, $clog2(NCH), channel-index width (derived)
- SW, LEGACY_WRAP ? DQW : DQW+1, sum width (derived)
---
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- scan_in0..scan_in4, scan_enable, test_mode  in  1 each  DFT hooks; functionally ignored
- scan_out0..scan_out4  out  1 each  DFT hooks; driven 0 in RTL
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- in_ch  in  CHW  channel of sample
- DQ  in  DQW  quantized difference, sign-magnitude
- SEZ  in  SEZW  partial signal estimate
- clr_valid  in  1  clear history of channel clr_ch
- clr_ch  in  CHW  channel to clear
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts
- out_ch  out  CHW  channel of result
- DQSEZ  out  SW  two's-complement sum
- PK0, SIGPK  out  1 each  sign of DQSEZ; DQSEZ==0
- PK1, PK2, SIG1, SIG2  out  1 each  PK0/SIGPK of previous and second-previous sample of out_ch

## Operation
- Conversion: DQI = DQ[DQW-1] ? −DQ[DQW-2:0] : DQ[DQW-2:0], sign-extended to DQW+1; negative zero (sign=1, mag=0) gives 0. SEZI = SEZ sign-extended to DQW+1.
- Sum: S = DQI + SEZI in DQW+1 bits (cannot overflow). DQSEZ = LEGACY_WRAP ? S[DQW-1:0] : S. PK0 = DQSEZ[SW-1]; SIGPK = (DQSEZ == 0).
- Stage 1 (S1): registers in_ch and DQSEZ.
- Stage 2 (S2): reads history of the S1 channel, registers outputs, and writes {PK0,SIGPK}→{PK1,SIG1} and old {PK1,SIG1}→{PK2,SIG2} for that channel.
- History array: NCH × {PK1,SIG1,PK2,SIG2} flops. Read and write occur only in S2, so back-to-back samples on the same channel always see the correct history (no forwarding needed).
- clr_valid zeroes all four history bits of clr_ch at the clock edge.
  - Same channel written by S2 in the same cycle: clear wins.
  - Clear does not alter data already in S1/S2 outputs.
- History is written only when S1→S2 advances.

## Timing
- Latency 2 cycles, in-accept to out_valid, when unstalled; throughput 1 sample/cycle.
- Pipeline enable: en = !out_valid | out_ready; in_ready = en (combinational). When en=0, all pipeline registers and history hold.
- Sample accepted iff in_valid & in_ready; result retired iff out_valid & out_ready. out_* stable while out_valid & !out_ready.
- Reset (async assert, sync deassert in clk domain): S1/S2 valid=0, out_valid=0, out_ch=0, DQSEZ=0, PK0..SIG2=0, all history=0. Reset mid-stream discards in-flight samples; the first post-reset sample on any channel sees PK1=PK2=SIG1=SIG2=0.

## Structure
- Package addc_pkg: sum/sign-magnitude conversion function (DQ→two's complement), history-entry struct {pk1,sig1,pk2,sig2}, default parameter constants.
- One sub-module, addc_hist: NCH-entry history register file with read port, write port and clear port (clear priority).
- Top level: conversion/adder, S1/S2 registers, handshake.

## Test plan
- NCH=4, DQW=16: DQ=16'h8005, SEZ=15'h0005, ch0 → DQSEZ=0, PK0=0, SIGPK=1, out after 2 cycles.
- DQ=16'h8000 (−0), SEZ=0 → SIGPK=1, PK0=0; DQ=16'h0003, SEZ=15'h7FFC → DQSEZ=−1, PK0=1.
- DQ=16'hFFFF, SEZ=15'h4000: LEGACY_WRAP=0 → DQSEZ=−49151, PK0=1; LEGACY_WRAP=1 → DQSEZ=16'h4001, PK0=0.
- Back-to-back ch2 samples giving PK0 1,0,1, interleaved with ch1 → third ch2 result PK1=0, PK2=1; ch1 history unaffected. Then clr_ch=2, same cycle as an S2 write to ch2 → next ch2 result PK1=PK2=0.
- out_ready low 5 cycles with stream in flight → in_ready=0, outputs held, no sample lost or duplicated; resume in order.
- Assert reset with 2 samples in flight → out_valid=0 immediately, all history 0 after release.
